// File: rtl/enigma_multi_rotor_if.sv
// Symbol/table handshake bundle for the Enigma multi-rotor core.
// The master drives load/encrypt strobes and receives the registered result.
interface enigma_multi_rotor_if #(
   parameter int SYM_W = 6,
   parameter int IDX_W = 2
);
   logic             load;
   logic             encrypt;
   logic [IDX_W-1:0] table_idx;
   logic [SYM_W-1:0] code_in;
   logic [SYM_W-1:0] code_out;
   logic             code_valid;

   modport master (
      output load, encrypt, table_idx, code_in,
      input  code_out, code_valid
   );

   modport slave (
      input  load, encrypt, table_idx, code_in,
      output code_out, code_valid
   );
endinterface

// File: rtl/enigma_multi_rotor.sv
// Enigma cipher core: plugboard, NUM_ROTORS odometer rotors, fixed reflector.
// Define ENIGMA_POS_OBS_EN to expose rotor positions on the rotor_pos port.
module enigma_multi_rotor #(
   parameter int SYM_W      = 6,
   parameter int NUM_ROTORS = 3
) (
   input  logic clk,
   input  logic srst_n,
   enigma_multi_rotor_if.slave bus
`ifdef ENIGMA_POS_OBS_EN
   ,
   output logic [NUM_ROTORS*SYM_W-1:0] rotor_pos
`endif
);
   localparam int NSYM  = 1 << SYM_W;
   localparam int IDX_W = $clog2(NUM_ROTORS + 1);

   typedef logic [SYM_W-1:0] sym_t;

   logic       load_q, load_d;
   logic       enc_q, enc_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] last_idx_q, last_idx_d;
   sym_t       code_in_q, code_in_d;
   sym_t       cnt_q, cnt_d;
   sym_t       out_q, out_d;
   logic       valid_q, valid_d;
   logic [NUM_ROTORS-1:0][SYM_W-1:0] pos_q, pos_d;

   sym_t rot_q  [NUM_ROTORS][NSYM];
   sym_t rinv_q [NUM_ROTORS][NSYM];
   sym_t pb_q   [NSYM];
   sym_t pbi_q  [NSYM];

   sym_t wr_ptr;
   logic rot_we;
   logic pb_we;
   logic go;
   sym_t res;

   always_comb begin
      load_d    = bus.load;
      enc_d     = bus.encrypt;
      idx_d     = bus.table_idx;
      code_in_d = bus.code_in;
   end

   // Table writes keep forward and inverse maps in step.
   always_ff @(posedge clk) begin
      if (rot_we) begin
         rot_q[idx_q][wr_ptr]     <= code_in_q;
         rinv_q[idx_q][code_in_q] <= wr_ptr;
      end
      if (pb_we) begin
         pb_q[wr_ptr]     <= code_in_q;
         pbi_q[code_in_q] <= wr_ptr;
      end
   end

   always_comb begin
      sym_t x;
      sym_t a;
      x = pb_q[code_in_q];
      for (int k = 0; k < NUM_ROTORS; k++) begin
         a = x + pos_q[k];
         x = rot_q[k][a] - pos_q[k];
      end
      x = ~x;
      for (int k = NUM_ROTORS - 1; k >= 0; k--) begin
         a = x + pos_q[k];
         x = rinv_q[k][a] - pos_q[k];
      end
      res = pbi_q[x];
   end

   always_comb begin
      logic carry;
      go         = enc_q & ~load_q;
      wr_ptr     = (idx_q == last_idx_q) ? cnt_q : '0;
      rot_we     = load_q && (32'(idx_q) < NUM_ROTORS);
      pb_we      = load_q && (32'(idx_q) == NUM_ROTORS);
      cnt_d      = load_q ? wr_ptr + sym_t'(1) : '0;
      last_idx_d = load_q ? idx_q : last_idx_q;
      out_d      = go ? res : '0;
      valid_d    = go;
      pos_d      = pos_q;
      carry      = 1'b1;
      if (load_q) begin
         pos_d = '0;
      end else if (enc_q) begin
         // Odometer: each rotor advances when all lower rotors wrap.
         for (int k = 0; k < NUM_ROTORS; k++) begin
            pos_d[k] = pos_q[k] + sym_t'(carry);
            carry    = carry & (&pos_q[k]);
         end
      end
   end

   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         load_q     <= 1'b0;
         enc_q      <= 1'b0;
         idx_q      <= '0;
         code_in_q  <= '0;
         last_idx_q <= '0;
         cnt_q      <= '0;
         out_q      <= '0;
         valid_q    <= 1'b0;
         pos_q      <= '0;
      end else begin
         load_q     <= load_d;
         enc_q      <= enc_d;
         idx_q      <= idx_d;
         code_in_q  <= code_in_d;
         last_idx_q <= last_idx_d;
         cnt_q      <= cnt_d;
         out_q      <= out_d;
         valid_q    <= valid_d;
         pos_q      <= pos_d;
      end
   end

   assign bus.code_out   = out_q;
   assign bus.code_valid = valid_q;

`ifdef ENIGMA_POS_OBS_EN
   assign rotor_pos = pos_q;
`endif
endmodule

// File: tb/tb_enigma_multi_rotor.sv
// Directed and random checks of enigma_multi_rotor against a rule-level model.
// Rotor positions are modelled as one base-64 message counter.
module tb_enigma_multi_rotor;
   localparam int NSYM  = 64;
   localparam int TOTAL = NSYM * NSYM * NSYM;

   logic clk;
   logic srst_n;
`ifdef ENIGMA_POS_OBS_EN
   logic [17:0] rotor_pos;
`endif

   enigma_multi_rotor_if #(.SYM_W(6), .IDX_W(2)) bus ();

   enigma_multi_rotor #(.SYM_W(6), .NUM_ROTORS(3)) dut (
      .clk    (clk),
      .srst_n (srst_n),
      .bus    (bus)
`ifdef ENIGMA_POS_OBS_EN
      ,
      .rotor_pos (rotor_pos)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int m_rot  [3][64];
   int m_rinv [3][64];
   int m_pb   [64];
   int m_pbi  [64];
   int ctr, m_cnt, m_last;
   int s_load, s_enc, s_idx, s_code;
   int exp_o, exp_v;
   int exp_q[$];
   int dut_q[$];
   int ident[64], aff[64], swp[64];
   int msg[200], ct[200];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic int m_enc(input int c, input int cv);
      int x, p;
      x = m_pb[c];
      for (int k = 0; k < 3; k++) begin
         p = (cv / (NSYM ** k)) % NSYM;
         x = (m_rot[k][(x + p) % NSYM] - p + NSYM) % NSYM;
      end
      x = NSYM - 1 - x;
      for (int k = 2; k >= 0; k--) begin
         p = (cv / (NSYM ** k)) % NSYM;
         x = (m_rinv[k][(x + p) % NSYM] - p + NSYM) % NSYM;
      end
      return m_pbi[x];
   endfunction

   task automatic model_reset();
      ctr = 0; m_cnt = 0; m_last = 0;
      s_load = 0; s_enc = 0; s_idx = 0; s_code = 0;
      exp_o = 0; exp_v = 0;
   endtask

   task automatic model_edge();
      int e;
      if (s_load != 0) begin
         e = (s_idx == m_last) ? m_cnt : 0;
         if (s_idx < 3) begin
            m_rot[s_idx][e]       = s_code;
            m_rinv[s_idx][s_code] = e;
         end else begin
            m_pb[e]       = s_code;
            m_pbi[s_code] = e;
         end
         m_cnt = (e + 1) % NSYM;
         m_last = s_idx;
         ctr = 0; exp_o = 0; exp_v = 0;
      end else begin
         m_cnt = 0;
         if (s_enc != 0) begin
            exp_o = m_enc(s_code, ctr);
            exp_v = 1;
            ctr = (ctr + 1) % TOTAL;
         end else begin
            exp_o = 0; exp_v = 0;
         end
      end
      s_load = int'(bus.load);
      s_enc  = int'(bus.encrypt);
      s_idx  = int'(bus.table_idx);
      s_code = int'(bus.code_in);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("valid", {31'd0, bus.code_valid}, exp_v);
      chk("code_out", {26'd0, bus.code_out}, exp_o);
`ifdef ENIGMA_POS_OBS_EN
      chk("rotor_pos", {14'd0, rotor_pos}, ctr);
`endif
      if (exp_v != 0) exp_q.push_back(exp_o);
      if (bus.code_valid === 1'b1) dut_q.push_back(int'(bus.code_out));
   endtask

   task automatic load_tab(input int idx, input int t[64]);
      for (int i = 0; i < 64; i++) begin
         bus.load      = 1'b1;
         bus.encrypt   = 1'b0;
         bus.table_idx = idx[1:0];
         bus.code_in   = t[i][5:0];
         tick();
      end
   endtask

   task automatic enc_one(input int v);
      bus.load    = 1'b0;
      bus.encrypt = 1'b1;
      bus.code_in = v[5:0];
      tick();
   endtask

   task automatic idle(input int n);
      bus.load    = 1'b0;
      bus.encrypt = 1'b0;
      bus.code_in = '0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         ident[i] = i;
         aff[i]   = (i * 5 + 7) % 64;
         swp[i]   = (i < 2) ? 1 - i : i;
      end
      srst_n = 1'b0;
      bus.load = 1'b0; bus.encrypt = 1'b0;
      bus.table_idx = '0; bus.code_in = '0;
      model_reset();
      #23;
      chk("rst_valid", {31'd0, bus.code_valid}, 0);
      chk("rst_out", {26'd0, bus.code_out}, 0);
`ifdef ENIGMA_POS_OBS_EN
      chk("rst_pos", {14'd0, rotor_pos}, 0);
`endif
      @(negedge clk);
      srst_n = 1'b1;

      // identity tables everywhere
      for (int t = 0; t < 4; t++) load_tab(t, ident);
      idle(1);
      dut_q.delete();
      enc_one(8'h00);
      enc_one(8'h05);
      enc_one(8'h3F);
      idle(2);
      chk("id_count", dut_q.size(), 3);
      chk("id_0", dut_q[0], 8'h3F);
      chk("id_1", dut_q[1], 8'h3A);
      chk("id_2", dut_q[2], 8'h00);

      // plugboard swap, then switch to rotor 1 without dropping load
      load_tab(3, swp);
      load_tab(1, ident);
      idle(1);
      dut_q.delete();
      enc_one(8'h00);
      idle(2);
      chk("pb_count", dut_q.size(), 1);
      chk("pb_swap", dut_q[0], 8'h3E);
      load_tab(3, ident);

      // involution with a non-trivial rotor 0
      load_tab(0, aff);
      idle(1);
      for (int i = 0; i < 200; i++) msg[i] = $urandom_range(0, 63);
      exp_q.delete();
      for (int i = 0; i < 200; i++) enc_one(msg[i]);
      idle(2);
      chk("ct_count", exp_q.size(), 200);
      for (int i = 0; i < 200; i++) ct[i] = exp_q[i];
      load_tab(0, aff);
      idle(1);
      dut_q.delete();
      for (int i = 0; i < 200; i++) enc_one(ct[i]);
      idle(2);
      chk("pt_count", dut_q.size(), 200);
      for (int i = 0; i < 200; i++) chk("plaintext", dut_q[i], msg[i]);

      // odometer stepping
      load_tab(0, aff);
      idle(1);
      for (int i = 0; i < 64; i++) enc_one($urandom_range(0, 63));
      idle(1);
`ifdef ENIGMA_POS_OBS_EN
      chk("pos_64", {14'd0, rotor_pos}, 18'h00040);
`endif
      for (int i = 64; i < 4096; i++) enc_one($urandom_range(0, 63));
      idle(1);
`ifdef ENIGMA_POS_OBS_EN
      chk("pos_4096", {14'd0, rotor_pos}, 18'h01000);
`endif

      // load and encrypt together: load wins
      bus.load = 1'b1; bus.encrypt = 1'b1;
      bus.table_idx = 2'd0; bus.code_in = 6'd7;
      tick();
      idle(1);
      chk("both_valid", {31'd0, bus.code_valid}, 0);
`ifdef ENIGMA_POS_OBS_EN
      chk("both_pos", {14'd0, rotor_pos}, 0);
`endif
      idle(1);

      // asynchronous reset mid-stream
      for (int i = 0; i < 5; i++) enc_one($urandom_range(0, 63));
      #2;
      srst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, bus.code_valid}, 0);
      chk("mid_rst_out", {26'd0, bus.code_out}, 0);
`ifdef ENIGMA_POS_OBS_EN
      chk("mid_rst_pos", {14'd0, rotor_pos}, 0);
`endif
      @(posedge clk);
      @(negedge clk);
      bus.load = 1'b0; bus.encrypt = 1'b0; bus.code_in = '0;
      model_reset();
      srst_n = 1'b1;
      for (int i = 0; i < 20; i++) enc_one($urandom_range(0, 63));
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
